// File: rtl/sc_frame_serializer.sv
// sc_frame_serializer
//
// Slow-control frame transmitter for MAROC-style chips. Latches a FRAME_W-bit
// configuration frame and shifts it out LSB-first on D_SC under a divided
// serial clock SCK_SC. After each pass it pulses LOAD_SC. In verify mode a
// second pass re-sends the frame. The chip's shift-register tail (Q_SC) is
// captured and compared with the latched frame.
//
// Ports:
//   CK        in   system clock, all logic on the rising edge
//   RST       in   synchronous active-high reset (aborts any sequence)
//   frame_in  in   frame to send, sampled only on an accepted start
//   start     in   one-cycle request, accepted only in IDLE
//   verify    in   sampled with start: 1 = write pass then verify pass
//   busy      out  high from the cycle after an accepted start until done
//   done      out  one-cycle pulse at the end of a sequence
//   match     out  verify result, held until the next accepted start
//   readback  out  Q_SC bits captured in the last pass, bit 0 = first captured
//   SCK_SC    out  serial clock to the chip, idles low
//   D_SC      out  serial data to the chip, holds its last bit outside SHIFT
//   Q_SC      in   serial data from the chip's shift-register tail
//   LOAD_SC   out  load strobe, high for DIV cycles per pass
//   state_dbg out  current FSM state (IDLE=0, SHIFT=1, LOAD=2, DONE=3)
//
// Handshake: start is a single-cycle request. It is taken only when busy is
// low and the FSM is in IDLE. Completion is signalled by one cycle of done.
// No backpressure exists on either side.
module sc_frame_serializer #(
    parameter int FRAME_W = 829,
    parameter int DIV     = 2
) (
    input  logic               CK,
    input  logic               RST,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               start,
    input  logic               verify,
    output logic               busy,
    output logic               done,
    output logic               match,
    output logic [FRAME_W-1:0] readback,
    output logic               SCK_SC,
    output logic               D_SC,
    input  logic               Q_SC,
    output logic               LOAD_SC,
    output logic [1:0]         state_dbg
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int DIV_W = $clog2(2 * DIV);

    localparam logic [DIV_W-1:0] C_HALF     = DIV_W'(DIV);
    localparam logic [DIV_W-1:0] C_HALF_M1  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] C_LAST     = DIV_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] readback_q, readback_d;
    logic               ver_q, ver_d;
    logic               pass_q, pass_d;
    logic               match_q, match_d;
    logic               sck_q, sck_d;
    logic               dsc_q, dsc_d;
    logic               load_q, load_d;
    logic [DIV_W-1:0]   cnt_inc;

    // Divider counter wraps every 2*DIV cycles in both SHIFT and LOAD.
    assign cnt_inc = (cnt_q == C_LAST) ? '0 : cnt_q + DIV_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        sreg_d     = sreg_q;
        rx_d       = rx_q;
        readback_d = readback_q;
        ver_d      = ver_q;
        pass_d     = pass_q;
        match_d    = match_q;
        sck_d      = sck_q;
        dsc_d      = dsc_q;
        load_d     = load_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d   = frame_in;
                    sreg_d    = frame_in;
                    ver_d     = verify;
                    pass_d    = 1'b0;
                    match_d   = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_inc;
                if (cnt_q == '0) begin
                    dsc_d = sreg_q[0];
                    sck_d = 1'b0;
                end
                // Chip shifts on this rising edge, so Q_SC still shows the
                // bit that was at its tail before the edge.
                if (cnt_q == C_HALF) begin
                    sck_d = 1'b1;
                    rx_d  = {Q_SC, rx_q[FRAME_W-1:1]};
                end
                if (cnt_q == C_LAST) begin
                    sreg_d    = sreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == C_BIT_LAST) begin
                        // With DIV=1 the last rising edge coincides with
                        // this cycle; the clock is then lowered in LOAD.
                        if (cnt_q != C_HALF) begin
                            sck_d = 1'b0;
                        end
                        load_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                cnt_d = cnt_inc;
                sck_d = 1'b0;
                if (cnt_q == C_HALF_M1) begin
                    load_d = 1'b0;
                end
                if (cnt_q == C_LAST) begin
                    if (!pass_q && ver_q) begin
                        pass_d    = 1'b1;
                        sreg_d    = frame_q;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                readback_d = rx_q;
                match_d    = ver_q & (rx_q == frame_q);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            sreg_q     <= '0;
            rx_q       <= '0;
            readback_q <= '0;
            ver_q      <= 1'b0;
            pass_q     <= 1'b0;
            match_q    <= 1'b0;
            sck_q      <= 1'b0;
            dsc_q      <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            sreg_q     <= sreg_d;
            rx_q       <= rx_d;
            readback_q <= readback_d;
            ver_q      <= ver_d;
            pass_q     <= pass_d;
            match_q    <= match_d;
            sck_q      <= sck_d;
            dsc_q      <= dsc_d;
            load_q     <= load_d;
        end
    end

    assign busy      = (state_q == S_SHIFT) || (state_q == S_LOAD);
    assign done      = (state_q == S_DONE);
    assign match     = match_q;
    assign readback  = readback_q;
    assign SCK_SC    = sck_q;
    assign D_SC      = dsc_q;
    assign LOAD_SC   = load_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sc_frame_serializer.sv
module tb_sc_frame_serializer;

    localparam int FW  = 829;
    localparam int DV  = 2;
    localparam int FWB = 8;
    localparam int DVB = 1;

    // ---------------- clock / reset ----------------
    logic CK  = 1'b0;
    logic RST = 1'b1;
    always #5 CK = ~CK;

    // ---------------- DUT A: 829 bits, DIV=2 ----------------
    logic          start_a = 1'b0;
    logic          verify_a = 1'b0;
    logic [FW-1:0] frame_a = '0;
    logic          busy_a, done_a, match_a, sck_a, d_a, q_a, load_a;
    logic [FW-1:0] readback_a;
    logic [1:0]    st_a;

    sc_frame_serializer #(.FRAME_W(FW), .DIV(DV)) dut_a (
        .CK(CK), .RST(RST), .frame_in(frame_a), .start(start_a), .verify(verify_a),
        .busy(busy_a), .done(done_a), .match(match_a), .readback(readback_a),
        .SCK_SC(sck_a), .D_SC(d_a), .Q_SC(q_a), .LOAD_SC(load_a), .state_dbg(st_a)
    );

    // ---------------- DUT B: 8 bits, DIV=1 ----------------
    logic           start_b = 1'b0;
    logic           verify_b = 1'b0;
    logic [FWB-1:0] frame_b = '0;
    logic           busy_b, done_b, match_b, sck_b, d_b, load_b;
    logic           q_b = 1'b0;
    logic [FWB-1:0] readback_b;
    logic [1:0]     st_b;

    sc_frame_serializer #(.FRAME_W(FWB), .DIV(DVB)) dut_b (
        .CK(CK), .RST(RST), .frame_in(frame_b), .start(start_b), .verify(verify_b),
        .busy(busy_b), .done(done_b), .match(match_b), .readback(readback_b),
        .SCK_SC(sck_b), .D_SC(d_b), .Q_SC(q_b), .LOAD_SC(load_b), .state_dbg(st_b)
    );

    // ---------------- chip model for DUT A ----------------
    // 829-bit shift register, shifts D_SC in at the top on SCK rise, tail on Q_SC.
    logic [FW-1:0] chip = '0;
    int            chip_rises = 0;
    logic          flip_en = 1'b0;
    int            flip_at = -1;

    always @(posedge sck_a) begin
        chip       <= {d_a, chip[FW-1:1]};
        chip_rises <= chip_rises + 1;
    end
    assign q_a = chip[0] ^ (flip_en && (chip_rises == flip_at));

    // ---------------- scoreboard ----------------
    int         chk_cnt  = 0;
    int         fail_cnt = 0;
    logic [0:0] exp_q[$];
    logic [0:0] exp_b_q[$];
    logic [0:0] exp_bit;
    int         rises_a = 0;
    logic       sck_a_prev = 1'b0;

    // Every SCK_SC rising edge on DUT A pops one expected D_SC bit.
    always @(negedge CK) begin
        if (sck_a && !sck_a_prev) begin
            rises_a++;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL d_sc_extra_rise rise=%0d got=%0b exp=none", rises_a, d_a);
            end else begin
                exp_bit = exp_q.pop_front();
                if (d_a !== exp_bit[0]) begin
                    fail_cnt++;
                    $display("FAIL d_sc_order rise=%0d got=%0b exp=%0b", rises_a, d_a, exp_bit[0]);
                end
            end
        end
        sck_a_prev = sck_a;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [FW-1:0] alt_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW; i++) f[i] = (i % 2 == 0);
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    // Drives a one-cycle start on DUT A and pushes expected D_SC bits.
    // Returns #1 after the accepting edge (cycle 0 ends there).
    task automatic start_a_seq(input logic [FW-1:0] f, input logic v, input bit wait_neg);
        if (wait_neg) @(negedge CK);
        frame_a  = f;
        verify_a = v;
        start_a  = 1'b1;
        for (int p = 0; p < (v ? 2 : 1); p++)
            for (int i = 0; i < FW; i++) exp_q.push_back(f[i]);
        @(posedge CK);
        #1;
        start_a = 1'b0;
        frame_a = ~f;  // changes while busy must have no effect
    endtask

    // Observes DUT A until done; collects timing figures for the caller to judge.
    task automatic run_a(input int budget, output int done_cyc, output int load_pulses,
                         output int load_cycles, output int busy_bad);
        logic prev_load;
        done_cyc = -1; load_pulses = 0; load_cycles = 0; busy_bad = 0; prev_load = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge CK);
            if (load_a) begin
                load_cycles++;
                if (!prev_load) load_pulses++;
            end
            prev_load = load_a;
            if (done_a) begin
                if (busy_a) busy_bad++;
                done_cyc = c;
                break;
            end else if (!busy_a) begin
                busy_bad++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        start_a = 1'b1;  // asserted together with RST: RST must win
        repeat (3) @(negedge CK);
        chk_cnt++; if (sck_a !== 1'b0)  begin fail_cnt++; $display("FAIL rst_sck got=%0b exp=0", sck_a); end
        chk_cnt++; if (d_a !== 1'b0)    begin fail_cnt++; $display("FAIL rst_dsc got=%0b exp=0", d_a); end
        chk_cnt++; if (load_a !== 1'b0) begin fail_cnt++; $display("FAIL rst_load got=%0b exp=0", load_a); end
        chk_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy got=%0b exp=0", busy_a); end
        chk_cnt++; if (done_a !== 1'b0) begin fail_cnt++; $display("FAIL rst_done got=%0b exp=0", done_a); end
        chk_cnt++; if (match_a !== 1'b0) begin fail_cnt++; $display("FAIL rst_match got=%0b exp=0", match_a); end
        chk_cnt++; if (readback_a !== '0) begin fail_cnt++; $display("FAIL rst_readback got_ones=%0d exp_ones=0", $countones(readback_a)); end
        chk_cnt++; if (readback_b !== '0) begin fail_cnt++; $display("FAIL rst_readback_b got=%0h exp=0", readback_b); end
        RST = 1'b0;
        start_a = 1'b0;
        @(negedge CK);
        chk_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL rst_start_ignored busy got=%0b exp=0", busy_a); end
    endtask

    task automatic test_write();
        logic [FW-1:0] f;
        int dc, lp, lc, bb, r0;
        f  = alt_frame();
        r0 = rises_a;
        start_a_seq(f, 1'b0, 1'b1);
        run_a(5000, dc, lp, lc, bb);
        chk_cnt++; if (dc !== 3321) begin fail_cnt++; $display("FAIL wr_done_cycle got=%0d exp=3321", dc); end
        chk_cnt++; if (lp !== 1) begin fail_cnt++; $display("FAIL wr_load_pulses got=%0d exp=1", lp); end
        chk_cnt++; if (lc !== 2) begin fail_cnt++; $display("FAIL wr_load_cycles got=%0d exp=2", lc); end
        chk_cnt++; if (bb !== 0) begin fail_cnt++; $display("FAIL wr_busy_window bad_cycles=%0d exp=0", bb); end
        chk_cnt++; if (rises_a - r0 !== FW) begin fail_cnt++; $display("FAIL wr_sck_rises got=%0d exp=%0d", rises_a - r0, FW); end
        @(negedge CK);
        chk_cnt++; if (match_a !== 1'b0) begin fail_cnt++; $display("FAIL wr_match got=%0b exp=0", match_a); end
        chk_cnt++; if (readback_a !== '0) begin fail_cnt++; $display("FAIL wr_readback_prev got_ones=%0d exp_ones=0", $countones(readback_a)); end
        chk_cnt++; if (d_a !== f[FW-1]) begin fail_cnt++; $display("FAIL wr_dsc_hold got=%0b exp=%0b", d_a, f[FW-1]); end
        chk_cnt++; if (exp_q.size() !== 0) begin fail_cnt++; $display("FAIL wr_bits_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_verify();
        logic [FW-1:0] f;
        int dc, lp, lc, bb, r0;
        f  = alt_frame();
        r0 = rises_a;
        start_a_seq(f, 1'b1, 1'b1);
        run_a(8000, dc, lp, lc, bb);
        chk_cnt++; if (dc !== 6641) begin fail_cnt++; $display("FAIL vf_done_cycle got=%0d exp=6641", dc); end
        chk_cnt++; if (lp !== 2) begin fail_cnt++; $display("FAIL vf_load_pulses got=%0d exp=2", lp); end
        chk_cnt++; if (lc !== 4) begin fail_cnt++; $display("FAIL vf_load_cycles got=%0d exp=4", lc); end
        chk_cnt++; if (bb !== 0) begin fail_cnt++; $display("FAIL vf_busy_window bad_cycles=%0d exp=0", bb); end
        chk_cnt++; if (rises_a - r0 !== 2 * FW) begin fail_cnt++; $display("FAIL vf_sck_rises got=%0d exp=%0d", rises_a - r0, 2 * FW); end
        @(negedge CK);
        chk_cnt++; if (match_a !== 1'b1) begin fail_cnt++; $display("FAIL vf_match got=%0b exp=1", match_a); end
        chk_cnt++; if (readback_a !== f) begin fail_cnt++; $display("FAIL vf_readback diff_bits=%0d exp_diff=0", $countones(readback_a ^ f)); end
    endtask

    task automatic test_verify_flip();
        logic [FW-1:0] f, exp_rb;
        int dc, lp, lc, bb;
        f       = alt_frame();
        exp_rb  = f;
        exp_rb[400] = ~exp_rb[400];
        flip_at = chip_rises + FW + 400;
        flip_en = 1'b1;
        start_a_seq(f, 1'b1, 1'b1);
        run_a(8000, dc, lp, lc, bb);
        flip_en = 1'b0;
        chk_cnt++; if (dc !== 6641) begin fail_cnt++; $display("FAIL flip_done_cycle got=%0d exp=6641", dc); end
        @(negedge CK);
        chk_cnt++; if (match_a !== 1'b0) begin fail_cnt++; $display("FAIL flip_match got=%0b exp=0", match_a); end
        chk_cnt++; if (readback_a !== exp_rb) begin fail_cnt++; $display("FAIL flip_readback diff_bits=%0d bit400 got=%0b exp=%0b", $countones(readback_a ^ exp_rb), readback_a[400], exp_rb[400]); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] fa, fb, prev;
        int dc, lp, lc, bb;
        prev = alt_frame();  // chip content left by the previous runs
        fa   = rand_frame();
        fb   = rand_frame();
        start_a_seq(fa, 1'b0, 1'b1);
        run_a(5000, dc, lp, lc, bb);
        chk_cnt++; if (dc !== 3321) begin fail_cnt++; $display("FAIL b2b_a_done got=%0d exp=3321", dc); end
        @(negedge CK);
        chk_cnt++; if (readback_a !== prev) begin fail_cnt++; $display("FAIL b2b_a_readback diff_bits=%0d exp_diff=0", $countones(readback_a ^ prev)); end
        // start in the cycle right after done must be taken
        start_a_seq(fb, 1'b0, 1'b0);
        run_a(5000, dc, lp, lc, bb);
        chk_cnt++; if (dc !== 3321) begin fail_cnt++; $display("FAIL b2b_b_done got=%0d exp=3321", dc); end
        @(negedge CK);
        chk_cnt++; if (readback_a !== fa) begin fail_cnt++; $display("FAIL b2b_b_readback diff_bits=%0d exp_diff=0", $countones(readback_a ^ fa)); end
        chk_cnt++; if (match_a !== 1'b0) begin fail_cnt++; $display("FAIL b2b_match got=%0b exp=0", match_a); end
    endtask

    task automatic test_abort();
        logic [FW-1:0] f;
        int dc, lp, lc, bb, n_done, n_load, r0;
        f = alt_frame();
        start_a_seq(f, 1'b0, 1'b1);
        for (int c = 1; c <= 1000; c++) @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        exp_q.delete();
        chk_cnt++; if (sck_a !== 1'b0)  begin fail_cnt++; $display("FAIL abort_sck got=%0b exp=0", sck_a); end
        chk_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL abort_busy got=%0b exp=0", busy_a); end
        chk_cnt++; if (d_a !== 1'b0)    begin fail_cnt++; $display("FAIL abort_dsc got=%0b exp=0", d_a); end
        n_done = 0; n_load = 0;
        for (int c = 0; c < 3400; c++) begin
            @(negedge CK);
            if (done_a) n_done++;
            if (load_a) n_load++;
        end
        chk_cnt++; if (n_done !== 0) begin fail_cnt++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        chk_cnt++; if (n_load !== 0) begin fail_cnt++; $display("FAIL abort_no_load got=%0d exp=0", n_load); end
        r0 = rises_a;
        start_a_seq(f, 1'b0, 1'b1);
        run_a(5000, dc, lp, lc, bb);
        chk_cnt++; if (dc !== 3321) begin fail_cnt++; $display("FAIL abort_rerun_done got=%0d exp=3321", dc); end
        chk_cnt++; if (lp !== 1) begin fail_cnt++; $display("FAIL abort_rerun_loads got=%0d exp=1", lp); end
        chk_cnt++; if (rises_a - r0 !== FW) begin fail_cnt++; $display("FAIL abort_rerun_rises got=%0d exp=%0d", rises_a - r0, FW); end
    endtask

    task automatic test_div1();
        logic [FWB-1:0] fb;
        logic [0:0]     eb;
        logic           prev_sck;
        int             dc, rises, lc, busy_after;
        fb = 8'hA5;
        @(negedge CK);
        frame_b = fb; verify_b = 1'b0; start_b = 1'b1;
        for (int i = 0; i < FWB; i++) exp_b_q.push_back(fb[i]);
        @(posedge CK);
        #1;
        start_b = 1'b0;
        dc = -1; rises = 0; lc = 0; prev_sck = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CK);
            if (sck_b && !prev_sck) begin
                rises++;
                chk_cnt++;
                if (exp_b_q.size() == 0) begin
                    fail_cnt++; $display("FAIL div1_extra_rise got=%0b exp=none", d_b);
                end else begin
                    eb = exp_b_q.pop_front();
                    if (d_b !== eb[0]) begin fail_cnt++; $display("FAIL div1_dsc bit=%0d got=%0b exp=%0b", rises - 1, d_b, eb[0]); end
                end
            end
            prev_sck = sck_b;
            if (load_b) lc++;
            if (done_b) begin dc = c; break; end
            start_b = (c == 5);  // second start while busy: must be ignored
        end
        start_b = 1'b0;
        chk_cnt++; if (dc !== 19) begin fail_cnt++; $display("FAIL div1_done got=%0d exp=19", dc); end
        chk_cnt++; if (rises !== 8) begin fail_cnt++; $display("FAIL div1_rises got=%0d exp=8", rises); end
        chk_cnt++; if (lc !== 1) begin fail_cnt++; $display("FAIL div1_load_cycles got=%0d exp=1", lc); end
        chk_cnt++; if (exp_b_q.size() !== 0) begin fail_cnt++; $display("FAIL div1_bits_left got=%0d exp=0", exp_b_q.size()); end
        busy_after = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CK);
            if (busy_b) busy_after++;
        end
        chk_cnt++; if (busy_after !== 0) begin fail_cnt++; $display("FAIL div1_second_start busy_cycles=%0d exp=0", busy_after); end
        chk_cnt++; if (d_b !== fb[FWB-1]) begin fail_cnt++; $display("FAIL div1_dsc_hold got=%0b exp=%0b", d_b, fb[FWB-1]); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write();
        test_verify();
        test_verify_flip();
        test_back_to_back();
        test_abort();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
